// File: rtl/eth_udp_rx_parser.sv
// Ethernet II / IPv4 / UDP receive parser: filters frames by header fields and
// destination port, then forwards only the UDP payload as a byte stream.
module eth_udp_rx_parser #(
  parameter logic [15:0] UDP_PORT = 16'd26400,
  parameter int unsigned CNT_W    = 16
) (
  input  logic             rxClkIn,
  input  logic             rstIn,
  input  logic [7:0]       rxDataIn,
  input  logic             rxDataValidIn,
  input  logic             rxDataLastIn,
  output logic [7:0]       payloadDataOut,
  output logic             payloadValidOut,
  output logic             payloadLastOut,
  output logic             frameDropOut,
  output logic             truncErrOut,
  output logic [CNT_W-1:0] frameCountOut,
  output logic [CNT_W-1:0] dropCountOut
);

  typedef enum logic [1:0] {IDLE, HDR, PAY, DRAIN} state_t;

  state_t      state, state_nxt;
  logic [10:0] byte_idx, byte_idx_nxt;
  logic [15:0] udp_len, udp_len_nxt;
  logic [15:0] pay_remain, pay_remain_nxt;
  logic        hdr_fail;
  logic        pay_valid_nxt, pay_last_nxt, drop_nxt, trunc_nxt, frame_inc;

  // Per-byte header filter; byte 41 also rejects a UDP length shorter than its own header.
  always_comb begin
    hdr_fail = 1'b0;
    case (byte_idx)
      11'd12:  hdr_fail = (rxDataIn != 8'h08);
      11'd13:  hdr_fail = (rxDataIn != 8'h00);
      11'd14:  hdr_fail = (rxDataIn != 8'h45);
      11'd23:  hdr_fail = (rxDataIn != 8'h11);
      11'd36:  hdr_fail = (rxDataIn != UDP_PORT[15:8]);
      11'd37:  hdr_fail = (rxDataIn != UDP_PORT[7:0]);
      11'd41:  hdr_fail = (udp_len < 16'd8);
      default: hdr_fail = 1'b0;
    endcase
  end

  always_comb begin
    state_nxt      = state;
    byte_idx_nxt   = byte_idx;
    udp_len_nxt    = udp_len;
    pay_remain_nxt = pay_remain;
    pay_valid_nxt  = 1'b0;
    pay_last_nxt   = 1'b0;
    drop_nxt       = 1'b0;
    trunc_nxt      = 1'b0;
    frame_inc      = 1'b0;

    if (rxDataValidIn) begin
      case (state)
        IDLE: begin
          if (rxDataLastIn) begin
            drop_nxt = 1'b1;
          end else begin
            state_nxt    = HDR;
            byte_idx_nxt = 11'd1;
          end
        end
        HDR: begin
          byte_idx_nxt = byte_idx + 11'd1;
          if (byte_idx == 11'd38) udp_len_nxt = {rxDataIn, udp_len[7:0]};
          if (byte_idx == 11'd39) udp_len_nxt = {udp_len[15:8], rxDataIn};
          if (hdr_fail) begin
            drop_nxt  = 1'b1;
            state_nxt = rxDataLastIn ? IDLE : DRAIN;
          end else if (byte_idx == 11'd41) begin
            if (udp_len == 16'd8) begin
              frame_inc = 1'b1;
              state_nxt = rxDataLastIn ? IDLE : DRAIN;
            end else if (rxDataLastIn) begin
              trunc_nxt = 1'b1;
              state_nxt = IDLE;
            end else begin
              pay_remain_nxt = udp_len - 16'd8;
              state_nxt      = PAY;
            end
          end else if (rxDataLastIn) begin
            drop_nxt  = 1'b1;
            state_nxt = IDLE;
          end
        end
        PAY: begin
          pay_valid_nxt  = 1'b1;
          pay_remain_nxt = pay_remain - 16'd1;
          if (pay_remain == 16'd1) begin
            pay_last_nxt = 1'b1;
            frame_inc    = 1'b1;
            state_nxt    = rxDataLastIn ? IDLE : DRAIN;
          end else if (rxDataLastIn) begin
            pay_last_nxt = 1'b1;
            trunc_nxt    = 1'b1;
            state_nxt    = IDLE;
          end
        end
        DRAIN: begin
          if (rxDataLastIn) state_nxt = IDLE;
        end
        default: state_nxt = IDLE;
      endcase
    end

    if (state_nxt == IDLE) byte_idx_nxt = '0;
  end

  // Output strobes are registered so every payload byte leaves exactly one cycle after it arrived.
  always_ff @(posedge rxClkIn or posedge rstIn) begin
    if (rstIn) begin
      state           <= IDLE;
      byte_idx        <= '0;
      udp_len         <= '0;
      pay_remain      <= '0;
      payloadDataOut  <= '0;
      payloadValidOut <= 1'b0;
      payloadLastOut  <= 1'b0;
      frameDropOut    <= 1'b0;
      truncErrOut     <= 1'b0;
      frameCountOut   <= '0;
      dropCountOut    <= '0;
    end else begin
      state           <= state_nxt;
      byte_idx        <= byte_idx_nxt;
      udp_len         <= udp_len_nxt;
      pay_remain      <= pay_remain_nxt;
      payloadValidOut <= pay_valid_nxt;
      payloadLastOut  <= pay_last_nxt;
      frameDropOut    <= drop_nxt;
      truncErrOut     <= trunc_nxt;
      if (pay_valid_nxt) payloadDataOut <= rxDataIn;
      if (frame_inc && (frameCountOut != '1)) frameCountOut <= frameCountOut + CNT_W'(1);
      if ((drop_nxt || trunc_nxt) && (dropCountOut != '1)) dropCountOut <= dropCountOut + CNT_W'(1);
    end
  end

endmodule
